// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- pipelined RISC-V immediate generator.
//
// Decodes instr[31:7] (presented on `in`) into an XLEN-bit immediate for the
// I, S, B, J, U and shift-amount formats, flags reserved selector codes, and
// queues each result in a DEPTH-entry in-order buffer with valid/ready
// handshakes on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (flushes the buffer)
//   in_valid   upstream presents an instruction/selector pair
//   in_ready   buffer has room (registered count only, also low in reset)
//   in[24:0]   instr[31:7]
//   ImmSrc     format selector: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT
//   out_valid  head entry valid
//   out_ready  downstream accepts the head entry
//   out        immediate at the head entry
//   out_src    selector captured with the head entry
//   illegal    head entry carried a reserved selector (110/111)
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     in,
  input  logic [2:0]      ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic [2:0]      out_src,
  output logic            illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [XLEN-1:0] r_imm [DEPTH];
  logic [2:0]      r_src [DEPTH];
  logic            r_ill [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_in_fire;
  logic            w_out_fire;

  // ---------------------------------------------------------------------
  // Immediate decode
  // ---------------------------------------------------------------------
  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (ImmSrc)
      3'b000: w_imm = {{(XLEN-12){in[24]}}, in[24:13]};
      3'b001: w_imm = {{(XLEN-12){in[24]}}, in[24:18], in[4:0]};
      3'b010: w_imm = {{(XLEN-13){in[24]}}, in[24], in[0], in[23:18], in[4:1], 1'b0};
      3'b011: w_imm = {{(XLEN-21){in[24]}}, in[24], in[12:5], in[13], in[23:14], 1'b0};
      // in[24] is both the sign and bit 31, so replicate it XLEN-31 times
      3'b100: w_imm = {{(XLEN-31){in[24]}}, in[23:5], 12'b0};
      3'b101: begin
        if (XLEN == 64) w_imm = {{(XLEN-6){1'b0}}, in[18:13]};
        else            w_imm = {{(XLEN-5){1'b0}}, in[17:13]};
      end
      default: begin
        w_imm = '0;
        w_ill = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  always_comb begin
    w_in_ready  = rst_n & (r_count < DEPTH_C);
    w_out_valid = (r_count != '0);
    w_in_fire   = in_valid & w_in_ready;
    w_out_fire  = w_out_valid & out_ready;
  end

  // ---------------------------------------------------------------------
  // Buffer state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_imm[i] <= '0;
        r_src[i] <= '0;
        r_ill[i] <= 1'b0;
      end
    end else begin
      if (w_in_fire) begin
        r_imm[r_wr_ptr] <= w_imm;
        r_src[r_wr_ptr] <= ImmSrc;
        r_ill[r_wr_ptr] <= w_ill;
        r_wr_ptr        <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_out_fire) begin
        r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_in_fire, w_out_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs come straight from the head entry
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = w_in_ready;
    out_valid = w_out_valid;
    out       = r_imm[r_rd_ptr];
    out_src   = r_src[r_rd_ptr];
    illegal   = r_ill[r_rd_ptr];
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: a 32-bit/DEPTH=2 instance and a
// 64-bit/DEPTH=3 instance share the input stream; a queue model per instance
// predicts handshake and head-entry values.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [24:0] in_d = '0;
  logic [2:0]  src = '0;

  logic        rdy32, ov32, ill32;
  logic [31:0] o32;
  logic [2:0]  os32;
  logic        rdy64, ov64, ill64;
  logic [63:0] o64;
  logic [2:0]  os64;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in(in_d), .ImmSrc(src), .out_valid(ov32), .out_ready(out_ready),
    .out(o32), .out_src(os32), .illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(3)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in(in_d), .ImmSrc(src), .out_valid(ov64), .out_ready(out_ready),
    .out(o64), .out_src(os64), .illegal(ill64)
  );

  typedef struct {
    logic [24:0] v;
    logic [2:0]  s;
  } ent_t;

  ent_t q32[$];
  ent_t q64[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the full 32-bit instruction word, standard
  // RISC-V field positions.
  function automatic logic [63:0] ref_imm(input logic [24:0] v, input logic [2:0] s, input bit x64);
    logic [31:0] ins;
    longint      si;
    logic [12:0] b;
    logic [20:0] j;
    ins = {v, 7'b0};
    si  = longint'($signed(ins));
    b   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (s)
      3'd0: return si >>> 20;
      3'd1: return ((si >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: return longint'($signed(b));
      3'd3: return longint'($signed(j));
      3'd4: return si & ~64'hFFF;
      3'd5: return x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref32(input logic [24:0] v, input logic [2:0] s);
    logic [63:0] t;
    t = ref_imm(v, s, 1'b0);
    return t[31:0];
  endfunction

  task automatic compare();
    chk("in_ready32", rdy32, rst_n && (q32.size() < 2));
    chk("out_valid32", ov32, q32.size() != 0);
    if (q32.size() != 0) begin
      chk("out32", o32, ref32(q32[0].v, q32[0].s));
      chk("out_src32", os32, q32[0].s);
      chk("illegal32", ill32, q32[0].s >= 3'd6);
    end
    chk("in_ready64", rdy64, rst_n && (q64.size() < 3));
    chk("out_valid64", ov64, q64.size() != 0);
    if (q64.size() != 0) begin
      chk("out64", o64, ref_imm(q64[0].v, q64[0].s, 1'b1));
      chk("out_src64", os64, q64[0].s);
      chk("illegal64", ill64, q64[0].s >= 3'd6);
    end
  endtask

  // One clock: model update on the rising edge, comparison on the falling edge.
  task automatic step();
    bit fi32, fo32, fi64, fo64;
    @(posedge clk);
    if (rst_n) begin
      fo32 = (q32.size() != 0) && out_ready;
      fi32 = in_valid && (q32.size() < 2);
      fo64 = (q64.size() != 0) && out_ready;
      fi64 = in_valid && (q64.size() < 3);
      if (fo32) void'(q32.pop_front());
      if (fi32) q32.push_back('{v: in_d, s: src});
      if (fo64) void'(q64.pop_front());
      if (fi64) q64.push_back('{v: in_d, s: src});
    end
    @(negedge clk);
    compare();
  endtask

  task automatic beat(input logic [24:0] v, input logic [2:0] s);
    in_valid = 1'b1;
    in_d     = v;
    src      = s;
    step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
  endtask

  logic [24:0] tv [11] = '{25'h1FFE001, 25'h0FFE001, 25'h1FC001D, 25'h1FC001D,
                           25'h0010000, 25'h02468A1, 25'h1FFE001, 25'h1FFE001,
                           25'h02468A1, 25'h0010000, 25'h1FC001D};
  logic [2:0]  ts [11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd4, 3'd7, 3'd1};
  logic [31:0] te [11] = '{32'hFFFFFFFF, 32'h000007FF, 32'hFFFFFFFD, 32'hFFFFFFFC,
                           32'h00000008, 32'h12345000, 32'h0000001F, 32'h0,
                           32'h12345000, 32'h0, 32'hFFFFFFFD};
  logic        ti [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};

  initial begin
    repeat (2) @(negedge clk);
    compare();
    chk("reset_out32", o32, 32'h0);
    chk("reset_src32", os32, 3'h0);
    chk("reset_ill32", ill32, 1'b0);
    chk("reset_out64", o64, 64'h0);
    rst_n = 1'b1;

    // Pin the reference model with hand-computed values.
    chk("pin_I", ref32(25'h1FFE001, 3'd0), 32'hFFFFFFFF);
    chk("pin_B", ref32(25'h1FC001D, 3'd2), 32'hFFFFFFFC);
    chk("pin_J", ref32(25'h0010000, 3'd3), 32'h00000008);
    chk("pin_U64", ref_imm(25'h1000000, 3'd4, 1'b1), 64'hFFFFFFFF80000000);
    chk("pin_SH64", ref_imm(25'h0060000, 3'd5, 1'b1), 64'h30);

    // Format sweep with illegal codes interleaved; streaming keeps the
    // newest beat at the head one cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      beat(tv[i], ts[i]);
      chk($sformatf("sweep%0d_out", i), o32, te[i]);
      chk($sformatf("sweep%0d_ill", i), ill32, ti[i]);
      chk($sformatf("sweep%0d_src", i), os32, ts[i]);
    end
    beat(25'h1000000, 3'd4);
    chk("u64_lit", o64, 64'hFFFFFFFF80000000);
    beat(25'h0060000, 3'd5);
    chk("shamt64_lit", o64, 64'h0000000000000030);
    drain();

    // Backpressure: DEPTH=2 instance fills and holds the third beat.
    out_ready = 1'b0;
    beat(25'h0000111 << 13, 3'd0);
    chk("full_rdy_after1", rdy32, 1'b1);
    beat(25'h0000222 << 13, 3'd0);
    chk("full_rdy_after2", rdy32, 1'b0);
    beat(25'h0000333 << 13, 3'd0);
    chk("full_head_held", o32, 32'h111);
    step();
    chk("full_still_blocked", rdy32, 1'b0);
    out_ready = 1'b1;
    step();
    chk("drain_rdy", rdy32, 1'b1);
    chk("drain_head2", o32, 32'h222);
    step();
    in_valid = 1'b0;
    chk("drain_head3", o32, 32'h333);
    step();
    step();
    chk("drain_empty", ov32, 1'b0);
    drain();

    // Streaming: one in, one out per cycle, count stays at 1.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(25'($urandom), 3'($urandom_range(0, 5)));
      chk("stream_valid", ov32, 1'b1);
      chk("stream_ready", rdy32, 1'b1);
    end
    drain();

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (i % 100 < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_d      = 25'($urandom);
      src       = 3'($urandom_range(0, 7));
      step();
    end
    drain();

    // Asynchronous reset with entries buffered.
    out_ready = 1'b0;
    beat(25'h02468A1, 3'd4);
    beat(25'h1FFE001, 3'd0);
    in_valid = 1'b0;
    chk("prereset_valid", ov32, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid32", ov32, 1'b0);
    chk("rst_async_ready32", rdy32, 1'b0);
    chk("rst_async_out32", o32, 32'h0);
    chk("rst_async_valid64", ov64, 1'b0);
    chk("rst_async_ready64", rdy64, 1'b0);
    chk("rst_async_out64", o64, 64'h0);
    q32.delete();
    q64.delete();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      step();
      chk("post_reset_no_stale", ov32, 1'b0);
    end

    for (int i = 0; i < 100; i++) begin
      in_valid  = $urandom_range(0, 1) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_d      = 25'($urandom);
      src       = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RISC-V datapath. It is the successor to the combinational extend unit. It decodes instr[31:7] into a sign- or zero-extended XLEN immediate for the I, S, B, J, U and shift-amount formats, and flags illegal selector codes. Output is registered into a DEPTH-entry in-order buffer with valid/ready handshakes on both sides, so it can sit between pipelined decode and execute stages.

Parameters:
XLEN, 32, output width; legal values 32 or 64.
DEPTH, 2, output buffer entries; must be 1 or more.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  an instruction/selector pair is presented.
in_ready  output  1  the block can accept a pair this cycle.
in  input  25  instr[31:7]; in[k] = instr[k+7].
ImmSrc  input  3  immediate format selector.
out_valid  output  1  the head buffer entry is valid.
out_ready  input  1  the consumer accepts the head entry.
out  output  XLEN  immediate at the head entry.
out_src  output  3  ImmSrc value captured with the head entry.
illegal  output  1  the head entry had an illegal ImmSrc.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Buffer is flushed and count = 0.
  - Pointers are 0.
  - out_valid = 0, out = 0, out_src = 0, illegal = 0.
  - in_ready = 0 while rst_n is low.
  - Reset asserted mid-transfer drops all buffered entries; none is emitted after release.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (count < DEPTH). It is a function of registered count only, with no combinational path from out_ready.
  - out_valid = (count != 0). out, out_src and illegal come straight from the head register.
  - The head entry stays stable while out_valid = 1 and out_ready = 0.
- Latency: a pair accepted at edge N is visible on out after edge N (1 cycle). Entries leave strictly in acceptance order.
- Simultaneous in_fire and out_fire: count is unchanged, and both pointers advance modulo DEPTH. Wrap-around is at DEPTH-1 to 0, and DEPTH need not be a power of two.
- When full (count = DEPTH), in_ready = 0 and the input is ignored even if in_valid = 1. There is no overwrite.
- When empty, out_ready has no effect.
- Decode (s() = sign-extend to XLEN, z() = zero-extend to XLEN):
  - 000 I: s(in[24:13])
  - 001 S: s({in[24:18], in[4:0]})
  - 010 B: s({in[24], in[0], in[23:18], in[4:1], 1'b0})
  - 011 J: s({in[24], in[12:5], in[13], in[23:14], 1'b0})
  - 100 U: s({in[24:5], 12'b0}); the upper 32 bits replicate in[24] when XLEN = 64.
  - 101 SHAMT: z(in[17:13]) when XLEN = 32; z(in[18:13]) when XLEN = 64.
  - 110, 111: illegal = 1 and out = 0. The entry is still buffered and emitted in order; nothing stalls.
- illegal = 0 for every legal code. out_src always equals the captured ImmSrc.

Test Plan:
- XLEN=32, out_ready=1. Present in=25'h1FFE001 with ImmSrc 000, then 25'h0FFE001 with 000. Required: the next cycles show out=32'hFFFFFFFF, then 32'h000007FF, with illegal=0.
- Format sweep, one beat each:
  - S: in=25'h1FC001D, ImmSrc 001 -> out=32'hFFFFFFFD.
  - B: in=25'h1FC001D, ImmSrc 010 -> out=32'hFFFFFFFC.
  - J: in=25'h0010000, ImmSrc 011 -> out=32'h00000008.
  - U: in=25'h02468A1, ImmSrc 100 -> out=32'h12345000.
  - SHAMT: in=25'h1FFE001, ImmSrc 101 -> out=32'h0000001F.
- DEPTH=2, out_ready=0, three back-to-back valid beats. Required: the first two are accepted; in_ready=0 from the cycle after the second accept; the third is held. Raising out_ready drains all three in order, with the third accepted as soon as count drops below 2.
- Streaming with in_valid=1 and out_ready=1 for 8 cycles. Required: one output per cycle, count stays at 1, and the pointers wrap without loss or duplication.
- ImmSrc 110 and 111 interleaved with legal beats. Required: out=0 and illegal=1 for exactly those entries, correct ordering, no stall.
- XLEN=64: U in=25'h1000000 -> out=64'hFFFFFFFF80000000; SHAMT in=25'h0060000 -> out=64'h0000000000000030.
- Reset: with 2 entries buffered, pulse rst_n low mid-cycle. Required: out_valid=0 immediately (asynchronous), in_ready=0 during reset, count=0 after release, and no stale entry is emitted afterwards.
